i2c_cmd_sequencer: RTL



---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_cmd_fifo.sv | 63 ++++++
 rtl/i2c_cmd_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C command sequencer: response status, sequencer state,
// and the packed command word stored in the command FIFO.
package i2c_pkg;

    typedef enum logic [1:0] {
        STAT_OK      = 2'b00,
        STAT_NACK    = 2'b01,
        STAT_TIMEOUT = 2'b10
    } status_e;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_LAUNCH,
        SEQ_WAIT_DONE,
        SEQ_REPORT,
        SEQ_DRAIN
    } seq_state_e;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// Ports: clk_400, rst_n (sync, active-low), push/din, pop/head, full, empty.
module i2c_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk_400,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count - 1'b1;
        end
    end

    // Flags are computed from the next occupancy so they are registered
    // yet exact in the cycle after every push/pop.
    always_ff @(posedge clk_400) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_d;
            full  <= (count_d == FULL_CNT);
            empty <= (count_d == '0);
        end
    end

    always_ff @(posedge clk_400) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Command stage for the I2C master: queues write/read commands, launches one
// bus transaction at a time and returns one response (rdata + status) per command.
// Ports: cmd_* valid/ready command in, rsp_* valid/ready response out,
// m_* master control/status, txn_count / err_count statistics.
module i2c_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_400,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [6:0]  cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic        m_start_txn,
    output logic        m_rw,
    output logic [6:0]  m_sub_addr,
    output logic [7:0]  m_data_in,
    output logic        m_next_byte,
    input  logic [7:0]  m_data_out,
    input  logic        m_data_ready,
    input  logic        m_busy,
    input  logic        m_done,
    input  logic        m_ack_error,
    output logic [15:0] txn_count,
    output logic [7:0]  err_count
);

    import i2c_pkg::*;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    cmd_t       in_cmd;
    cmd_t       head_cmd;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    seq_state_e state;
    seq_state_e state_d;
    status_e    status_d;
    logic       finish;
    logic [7:0] tmo_cnt;
    logic [7:0] rdata_cap;
    logic [7:0] rdata_now;

    assign cmd_ready   = !fifo_full;
    assign push        = cmd_valid && cmd_ready;
    assign m_next_byte = 1'b0;
    assign in_cmd      = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};

    i2c_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk_400 (clk_400),
        .rst_n   (rst_n),
        .push    (push),
        .din     (in_cmd),
        .pop     (pop),
        .head    (head_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A read byte strobed in the same cycle as m_done still counts.
    assign rdata_now = (m_data_ready && m_rw) ? m_data_out : rdata_cap;

    always_comb begin
        state_d  = state;
        pop      = 1'b0;
        finish   = 1'b0;
        status_d = STAT_OK;
        unique case (state)
            SEQ_IDLE: begin
                if (!fifo_empty && !m_busy && !m_done) begin
                    pop     = 1'b1;
                    state_d = SEQ_LAUNCH;
                end
            end
            SEQ_LAUNCH: begin
                state_d = SEQ_WAIT_DONE;
            end
            SEQ_WAIT_DONE: begin
                if (m_done) begin
                    finish   = 1'b1;
                    status_d = m_ack_error ? STAT_NACK : STAT_OK;
                    state_d  = SEQ_REPORT;
                end else if (tmo_cnt == TMO_LIMIT - 8'd1) begin
                    // this cycle is the TIMEOUT_CYCLES-th in WAIT_DONE
                    finish   = 1'b1;
                    status_d = STAT_TIMEOUT;
                    state_d  = SEQ_REPORT;
                end
            end
            SEQ_REPORT: begin
                if (rsp_ready) state_d = SEQ_DRAIN;
            end
            SEQ_DRAIN: begin
                // master may still show done/busy during its STOP phase
                if (!m_done && !m_busy) state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_400) begin
        if (!rst_n) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk_400) begin
        if (!rst_n) begin
            m_start_txn <= 1'b0;
            m_rw        <= 1'b0;
            m_sub_addr  <= '0;
            m_data_in   <= '0;
            tmo_cnt     <= '0;
            rdata_cap   <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_status  <= STAT_OK;
            txn_count   <= '0;
            err_count   <= '0;
        end else begin
            m_start_txn <= (state_d == SEQ_LAUNCH);
            if (pop) begin
                m_rw       <= head_cmd.rw;
                m_sub_addr <= head_cmd.addr;
                m_data_in  <= head_cmd.wdata;
            end
            if (state == SEQ_LAUNCH) begin
                tmo_cnt   <= '0;
                rdata_cap <= '0;
            end
            if (state == SEQ_WAIT_DONE) begin
                tmo_cnt <= tmo_cnt + 8'd1;
                if (m_data_ready && m_rw) rdata_cap <= m_data_out;
            end
            if (finish) begin
                rsp_valid  <= 1'b1;
                rsp_status <= status_d;
                rsp_rdata  <= (status_d == STAT_OK && m_rw) ? rdata_now : 8'h00;
            end
            if (state == SEQ_REPORT && rsp_ready) begin
                rsp_valid <= 1'b0;
                txn_count <= txn_count + 16'd1;
                if (rsp_status != STAT_OK && err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule
